// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: FSM states, access-size
// encodings (shared with the load unit's extension select) and alignment rule.
package dmem_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_WAIT = 2'b10,
      ST_DONE = 2'b11
   } state_t;

   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic bad;
      case (size)
         SZ_WORD: bad = (addr_lo != 2'b00);
         SZ_HALF: bad = addr_lo[0];
         SZ_BYTE: bad = 1'b0;
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Word-wide data-memory bus between the controller (master) and memory (slave).
interface dmem_ctrl_if #(
   parameter int AW = 32
) ();
   // mem_req is held with stable we/addr/be/wdata until the cycle mem_gnt is seen
   // high; one mem_rvalid (read data or write ack) follows, possibly in the grant cycle.
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [3:0]    mem_be;
   logic [31:0]   mem_wdata;
   logic          mem_gnt;
   logic          mem_rvalid;
   logic [31:0]   mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_gnt, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/dmem_ctrl_align.sv
// Byte-lane steering: store data/byte enables onto the word bus and load data
// back to a right-justified, zero-filled value.
module dmem_align
   import dmem_ctrl_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_lane,
   output logic [31:0] rdata_out
);
   logic [4:0]  shamt;
   logic [31:0] rshift;

   assign shamt  = {addr_lo, 3'b000};
   assign rshift = rdata >> shamt;

   always_comb begin
      be         = 4'b0000;
      wdata_lane = wdata;
      rdata_out  = rdata;
      case (size)
         SZ_WORD: be = 4'b1111;
         SZ_HALF: begin
            be         = 4'b0011 << addr_lo;
            wdata_lane = wdata << shamt;
            rdata_out  = {16'h0000, rshift[15:0]};
         end
         SZ_BYTE: begin
            be         = 4'b0001 << addr_lo;
            wdata_lane = wdata << shamt;
            rdata_out  = {24'h000000, rshift[7:0]};
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/dmem_ctrl.sv
// Load/store bus controller: one aligned access per request, request/grant/response
// with a cycle budget, pipeline stall while outstanding.
module dmem_ctrl
   import dmem_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 64,
   parameter int AW      = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   input  logic          req_we,
   input  logic [1:0]    req_size,
   input  logic [AW-1:0] req_addr,
   input  logic [31:0]   req_wdata,
   output logic [31:0]   rd_data,
   output logic          done,
   output logic          err,
   output logic          stall,
   output state_t        dbg_state,
   dmem_ctrl_if.master   bus
);
   localparam int CW = $clog2(TIMEOUT + 1);

   state_t        state, state_next;
   logic [CW-1:0] tmo_cnt;
   logic [1:0]    size_q, addr_lo_q;
   logic          we_q;
   logic          misaligned, accept, capture, expired;
   logic [1:0]    al_size, al_addr_lo;
   logic [3:0]    al_be;
   logic [31:0]   al_wdata, al_rdata;

   assign misaligned = is_misaligned(req_size, req_addr[1:0]);
   assign accept     = (state == ST_IDLE) && req_valid && !misaligned;
   assign capture    = ((state == ST_WAIT) && bus.mem_rvalid) ||
                       ((state == ST_REQ) && bus.mem_gnt && bus.mem_rvalid);
   assign expired    = (tmo_cnt == CW'(TIMEOUT - 1));

   assign stall     = accept || (state == ST_REQ) || (state == ST_WAIT);
   assign done      = (state == ST_DONE);
   assign dbg_state = state;

   // Steer from the live request while idle, from the latched access otherwise.
   assign al_size    = (state == ST_IDLE) ? req_size : size_q;
   assign al_addr_lo = (state == ST_IDLE) ? req_addr[1:0] : addr_lo_q;

   dmem_align u_align (
      .size       (al_size),
      .addr_lo    (al_addr_lo),
      .wdata      (req_wdata),
      .rdata      (bus.mem_rdata),
      .be         (al_be),
      .wdata_lane (al_wdata),
      .rdata_out  (al_rdata)
   );

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (accept) state_next = ST_REQ;
         ST_REQ: begin
            if (capture)          state_next = ST_DONE;
            else if (expired)     state_next = ST_IDLE;
            else if (bus.mem_gnt) state_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (capture)      state_next = ST_DONE;
            else if (expired) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         tmo_cnt       <= '0;
         size_q        <= SZ_WORD;
         addr_lo_q     <= 2'b00;
         we_q          <= 1'b0;
         rd_data       <= '0;
         err           <= 1'b0;
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_be    <= 4'b0000;
         bus.mem_wdata <= '0;
      end else begin
         state       <= state_next;
         bus.mem_req <= (state_next == ST_REQ);
         // Pulses for a rejected access or an aborted (timed-out) transaction.
         err <= ((state == ST_IDLE) && req_valid && misaligned) ||
                (((state == ST_REQ) || (state == ST_WAIT)) && (state_next == ST_IDLE));
         if (accept) begin
            tmo_cnt       <= '0;
            size_q        <= req_size;
            addr_lo_q     <= req_addr[1:0];
            we_q          <= req_we;
            bus.mem_we    <= req_we;
            bus.mem_addr  <= {req_addr[AW-1:2], 2'b00};
            bus.mem_be    <= al_be;
            bus.mem_wdata <= al_wdata;
         end else if ((state == ST_REQ) || (state == ST_WAIT)) begin
            tmo_cnt <= tmo_cnt + CW'(1);
         end
         if (capture && !we_q) rd_data <= al_rdata;
      end
   end
endmodule
